// File: rtl/metronome_tone_beat_detector.sv
// Listens to the metronome speaker square wave, classifies each tone as C# or accented G#,
// and counts beats 1..8 for a common 7-segment digit.
module metronome_tone_beat_detector #(
   parameter int unsigned C_SHARP_PERIOD = 97408,
   parameter int unsigned G_SHARP_PERIOD = 65014,
   parameter int unsigned TOL            = 2048,
   parameter int unsigned CONFIRM        = 2,
   parameter int unsigned SILENCE_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        audio_in,
   output logic        tone_valid,
   output logic        tone_is_accent,
   output logic        beat_pulse,
   output logic [3:0]  beat_num,
   output logic [17:0] period_out,
   output logic        err_unknown,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        e,
   output logic        f,
   output logic        g
);
   localparam int unsigned MW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
   localparam logic [MW-1:0] CONF_M = MW'(CONFIRM);
   localparam logic [17:0] SIL = 18'(SILENCE_CYCLES);
   localparam logic [18:0] C_LO = 19'((C_SHARP_PERIOD > TOL) ? C_SHARP_PERIOD - TOL : 0);
   localparam logic [18:0] C_HI = 19'(C_SHARP_PERIOD + TOL);
   localparam logic [18:0] G_LO = 19'((G_SHARP_PERIOD > TOL) ? G_SHARP_PERIOD - TOL : 0);
   localparam logic [18:0] G_HI = 19'(G_SHARP_PERIOD + TOL);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACQUIRE = 2'd1, ST_TONE = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [2:0]    in_q, in_d;
   logic [17:0]   cnt_q, cnt_d;
   logic [17:0]   period_q, period_d;
   logic [MW-1:0] match_q, match_d, match_inc;
   logic          cls_q, cls_d;
   logic          tone_valid_q, tone_valid_d;
   logic          accent_q, accent_d;
   logic          pulse_q, pulse_d;
   logic          err_q, err_d;
   logic [3:0]    beat_q, beat_d, beat_next;
   logic [6:0]    seg_q, seg_d;
   logic          edge_w, timeout_w, is_c, is_g, known_w, cls_now;
   logic [18:0]   period_w;

   // in_q[0..1] is the synchronizer, in_q[2] the delayed copy used for edge detection.
   always_comb begin
      in_d      = {in_q[1:0], audio_in};
      edge_w    = in_q[1] & ~in_q[2];
      timeout_w = (cnt_q == SIL);
      period_w  = {1'b0, cnt_q} + 19'd1;
      is_c      = (period_w >= C_LO) && (period_w <= C_HI);
      is_g      = (period_w >= G_LO) && (period_w <= G_HI);
      known_w   = is_c | is_g;
      cls_now   = ~is_c & is_g;
      match_inc = (cls_now == cls_q) ? match_q + MW'(1) : MW'(1);
      if (cls_now) begin
         beat_next = (beat_q >= 4'd4 && beat_q <= 4'd7) ? 4'd8 : 4'd4;
      end else begin
         beat_next = (beat_q == 4'd0 || beat_q == 4'd8) ? 4'd1 : beat_q + 4'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = timeout_w ? cnt_q : cnt_q + 18'd1;
      period_d     = period_q;
      match_d      = match_q;
      cls_d        = cls_q;
      tone_valid_d = tone_valid_q;
      accent_d     = accent_q;
      pulse_d      = 1'b0;
      err_d        = 1'b0;
      beat_d       = beat_q;
      if (edge_w) begin
         cnt_d    = 18'd0;
         period_d = period_w[17:0];
         // A timeout coinciding with an edge restarts acquisition from that edge.
         if (state_q == ST_IDLE || timeout_w) begin
            state_d      = ST_ACQUIRE;
            match_d      = '0;
            tone_valid_d = 1'b0;
         end else begin
            err_d = ~known_w;
            if (state_q == ST_ACQUIRE) begin
               if (!known_w) begin
                  match_d = '0;
               end else begin
                  match_d = match_inc;
                  cls_d   = cls_now;
                  if (match_inc == CONF_M) begin
                     state_d      = ST_TONE;
                     tone_valid_d = 1'b1;
                     accent_d     = cls_now;
                     pulse_d      = 1'b1;
                     beat_d       = beat_next;
                  end
               end
            end
         end
      end else if (timeout_w) begin
         state_d      = ST_IDLE;
         tone_valid_d = 1'b0;
      end
   end

   always_comb begin
      case (beat_q)
         4'd0:    seg_d = 7'b1111110;
         4'd1:    seg_d = 7'b0110000;
         4'd2:    seg_d = 7'b1101101;
         4'd3:    seg_d = 7'b1111001;
         4'd4:    seg_d = 7'b0110011;
         4'd5:    seg_d = 7'b1011011;
         4'd6:    seg_d = 7'b1011111;
         4'd7:    seg_d = 7'b1110000;
         4'd8:    seg_d = 7'b1111111;
         default: seg_d = 7'b0000000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         in_q         <= 3'b000;
         cnt_q        <= 18'd0;
         period_q     <= 18'd0;
         match_q      <= '0;
         cls_q        <= 1'b0;
         tone_valid_q <= 1'b0;
         accent_q     <= 1'b0;
         pulse_q      <= 1'b0;
         err_q        <= 1'b0;
         beat_q       <= 4'd0;
         seg_q        <= 7'b1111110;
      end else begin
         state_q      <= state_d;
         in_q         <= in_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         match_q      <= match_d;
         cls_q        <= cls_d;
         tone_valid_q <= tone_valid_d;
         accent_q     <= accent_d;
         pulse_q      <= pulse_d;
         err_q        <= err_d;
         beat_q       <= beat_d;
         seg_q        <= seg_d;
      end
   end

   assign tone_valid     = tone_valid_q;
   assign tone_is_accent = accent_q;
   assign beat_pulse     = pulse_q;
   assign beat_num       = beat_q;
   assign period_out     = period_q;
   assign err_unknown    = err_q;
   assign {a, b, c, d, e, f, g} = seg_q;
endmodule
